// File: rtl/axi4_lite_write_slave_regs_if.sv
// AXI4-Lite write-channel bundle (AW, W and B channels).
// The master drives the address, data, strobes, valids and BREADY.
// The slave drives AWREADY, WREADY, BRESP and BVALID.
interface axi4_lite_write_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );
endinterface

// File: rtl/axi4_lite_write_slave_regs.sv
// AXI4-Lite write slave terminating AW/W/B into NUM_REGS 32-bit registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_axi        : AXI4-Lite write channels (slave modport)
//   rd_index     : local read select; rd_data is regs[rd_index] (combinational)
//   wr_pulse     : one-cycle pulse after each successful register update
//   wr_index     : register index written, valid while wr_pulse
//   err_count    : saturating count of SLVERR responses
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | readies follow AWVALID & WVALID; joint handshake decodes/writes
// ST_RESP | BVALID high with the registered BRESP until BREADY is seen
module axi4_lite_write_slave_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi4_lite_write_slave_regs_if.slave s_axi,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_pulse,
    output logic [IDX_W-1:0]      wr_index,
    output logic [15:0]           err_count
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]      wr_index_q, wr_index_d;
    logic [15:0]           err_count_q, err_count_d;

    logic                  handshake;
    logic [ADDR_WIDTH-1:0] off;
    logic                  addr_ok;
    logic [IDX_W-1:0]      idx;

    // Both readies are the same signal: AW or W alone is never accepted.
    assign handshake           = (state_q == ST_IDLE) & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign s_axi.S_AXI_AWREADY = handshake;
    assign s_axi.S_AXI_WREADY  = handshake;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;

    // Offset wraps at ADDR_WIDTH; the explicit >= BASE_ADDR test rejects
    // addresses below the window that would otherwise wrap into range.
    assign off     = s_axi.S_AXI_AWADDR - BASE_ADDR;
    assign addr_ok = (s_axi.S_AXI_AWADDR >= BASE_ADDR) && (off[1:0] == 2'b00) &&
                     ((off >> 2) < ADDR_WIDTH'(NUM_REGS));
    assign idx     = off[2 +: IDX_W];

    assign rd_data   = regs_q[rd_index];
    assign wr_pulse  = wr_pulse_q;
    assign wr_index  = wr_index_q;
    assign err_count = err_count_q;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_pulse_d  = 1'b0;
        wr_index_d  = wr_index_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d  = ST_RESP;
                    bvalid_d = 1'b1;
                    if (addr_ok) begin
                        for (int b = 0; b < DATA_WIDTH/8; b++) begin
                            if (s_axi.S_AXI_WSTRB[b]) begin
                                regs_d[idx][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
                            end
                        end
                        // Pulses even with WSTRB == 0 so software sees every accepted write.
                        wr_pulse_d = 1'b1;
                        wr_index_d = idx;
                        bresp_d    = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            wr_pulse_q  <= 1'b0;
            wr_index_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_index_q  <= wr_index_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_write_slave_regs.sv
module tb_axi4_lite_write_slave_regs;
    localparam int          NR   = 16;
    localparam int          IW   = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    axi4_lite_write_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    logic [IW-1:0] rd_index;
    logic [31:0]   rd_data;
    logic          wr_pulse;
    logic [IW-1:0] wr_index;
    logic [15:0]   err_count;

    axi4_lite_write_slave_regs #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus),
        .rd_index(rd_index), .rd_data(rd_data),
        .wr_pulse(wr_pulse), .wr_index(wr_index), .err_count(err_count)
    );

    typedef struct {
        logic [1:0]    bresp;
        logic          pulse;
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mreg [NR];
    int          exp_err = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
    endtask

    task automatic idle_bus();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
    endtask

    // Called in the low phase of the handshake cycle: checks readies and the
    // old register value, then updates the model and queues the expectation.
    task automatic accept(input string tag);
        exp_t        e;
        logic [63:0] a, lo, hi;
        int          ix;
        #1;
        check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
        check({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd1);
        a  = {32'd0, bus.S_AXI_AWADDR};
        lo = {32'd0, BASE};
        hi = lo + 64'(4 * NR);
        if (a < lo || a >= hi || a[1:0] != 2'b00) begin
            e = '{bresp: 2'b10, pulse: 1'b0, idx: '0, data: 32'd0};
            if (exp_err != 65535) exp_err++;
        end else begin
            ix = int'((a - lo) >> 2);
            rd_index = IW'(ix);
            #1;
            check({tag, "_same_cycle_old"}, rd_data, mreg[ix]);
            for (int b = 0; b < 4; b++)
                if (bus.S_AXI_WSTRB[b]) mreg[ix][8*b +: 8] = bus.S_AXI_WDATA[8*b +: 8];
            e = '{bresp: 2'b00, pulse: 1'b1, idx: IW'(ix), data: mreg[ix]};
        end
        sb.push_back(e);
    endtask

    // Called in the low phase of the cycle after the handshake.
    task automatic resp_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard: observed empty queue required one entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_bvalid"},    32'(bus.S_AXI_BVALID), 32'd1);
        check({tag, "_bresp"},     32'(bus.S_AXI_BRESP),  32'(e.bresp));
        check({tag, "_wr_pulse"},  32'(wr_pulse),         32'(e.pulse));
        check({tag, "_err_count"}, 32'(err_count),        32'(exp_err));
        if (e.pulse) begin
            check({tag, "_wr_index"}, 32'(wr_index), 32'(e.idx));
            rd_index = e.idx;
            #1;
            check({tag, "_rd_data"}, rd_data, e.data);
        end
    endtask

    task automatic write_full(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        @(negedge clk);
        present(a, d, s);
        accept(tag);
        @(negedge clk);
        idle_bus();
        resp_check(tag);
        @(negedge clk);
        #1;
        check({tag, "_bvalid_drop"}, 32'(bus.S_AXI_BVALID), 32'd0);
        check({tag, "_pulse_drop"},  32'(wr_pulse),          32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc [4];
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        rd_index = '0;

        // Reset values
        #12;
        check("rst_bvalid",    32'(bus.S_AXI_BVALID),  32'd0);
        check("rst_bresp",     32'(bus.S_AXI_BRESP),   32'd0);
        check("rst_awready",   32'(bus.S_AXI_AWREADY), 32'd0);
        check("rst_wr_pulse",  32'(wr_pulse),          32'd0);
        check("rst_wr_index",  32'(wr_index),          32'd0);
        check("rst_err_count", 32'(err_count),         32'd0);
        check("rst_rd_data",   rd_data,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full write and partial strobe
        write_full("full", BASE + 32'd8, 32'hDEADBEEF, 4'hF);
        write_full("partial", BASE + 32'd8, 32'h11223344, 4'b0101);
        rd_index = 4'd2;
        #1;
        check("partial_const", rd_data, 32'hDE22BE44);

        // Decode errors
        write_full("err_range", BASE + 32'(4 * NR), 32'hFFFFFFFF, 4'hF);
        write_full("err_unalign", BASE + 32'd6, 32'hFFFFFFFF, 4'hF);
        write_full("err_below", BASE - 32'd4, 32'hFFFFFFFF, 4'hF);
        check("err_count3", 32'(err_count), 32'd3);
        rd_index = 4'd2;
        #1;
        check("err_no_change", rd_data, 32'hDE22BE44);

        // Split valids
        @(negedge clk);
        present(BASE + 32'd4, 32'hCAFE0001, 4'hF);
        bus.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("split_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
            check("split_wready",  32'(bus.S_AXI_WREADY),  32'd0);
            @(negedge clk);
        end
        bus.S_AXI_WVALID = 1'b1;
        accept("split");
        @(negedge clk);
        idle_bus();
        resp_check("split");
        @(negedge clk);
        #1;
        check("split_one_write", 32'(wr_pulse), 32'd0);

        // BREADY backpressure
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        present(BASE + 32'd12, 32'h0BAD_F00D, 4'hF);
        accept("hold");
        @(negedge clk);
        idle_bus();
        resp_check("hold");
        present(BASE + 32'd0, 32'hAA55AA55, 4'hF);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
            check("hold_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
            check("hold_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
            if (k < 4) @(negedge clk);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        accept("queued");
        @(negedge clk);
        idle_bus();
        resp_check("queued");

        // Zero strobe on a legal address
        write_full("zero_strb", BASE + 32'd20, 32'hFFFFFFFF, 4'h0);

        // Back-to-back writes, reset during the third response
        @(negedge clk);
        present(BASE, 32'h1000_0000, 4'hF);
        for (int i = 0; i < 4; i++) begin
            accept("b2b");
            t_acc[i] = cyc;
            if (i > 0) check("b2b_spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd2);
            @(negedge clk);
            resp_check("b2b");
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                check("midrst_bvalid",    32'(bus.S_AXI_BVALID), 32'd0);
                check("midrst_err_count", 32'(err_count),        32'd0);
                idle_bus();
                sb.delete();
                exp_err = 0;
                for (int j = 0; j < NR; j++) mreg[j] = '0;
                for (int j = 0; j < NR; j++) begin
                    rd_index = IW'(j);
                    #1;
                    check("midrst_regs", rd_data, 32'd0);
                end
                break;
            end
            present(BASE + 32'(4 * (i + 1)), 32'h1000_0000 + 32'(i + 1), 4'hF);
            #1;
            check("b2b_busy_ready", 32'(bus.S_AXI_AWREADY), 32'd0);
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset
        write_full("recover", BASE + 32'd60, 32'h5A5A_1234, 4'b1100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
